read_processor: RTL and testbench

Read-side controller of the RX elastic buffer. It pops 13-bit symbol words from the buffer's show-ahead read port and presents them, registered, to the downstream RX pipeline. When the level monitor requests SKP insertion because the buffer is running low, it inserts SKP copies into the SKP ordered set without popping. It is the insertion counterpart of the write-side SKP deletion logic: groups of 4, at most 8 per ordered set.

---
 rtl/ebuf_pkg.sv | 25 ++
 rtl/read_processor.sv | 166 ++++++++++++++++
 tb/tb_read_processor.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ebuf_pkg.sv
// ---------------------------------------------------------------------------
// ebuf_pkg
// Shared constants and types for the RX elastic buffer. Used by the
// read-side SKP insertion logic and the write-side SKP deletion logic.
//   SKP_WORD      : {OS flag, symbol} pattern of a SKP symbol
//   IDX_MSB/LSB   : position of the symbol index inside a buffer word
//   NO_OS_IDX     : index value meaning "not inside an ordered set"
//   MAX_SKP_CHG   : most SKPs that may be added/removed per ordered set
//   HALF_SKP_CHG  : size of one SKP add/remove group
// ---------------------------------------------------------------------------
package ebuf_pkg;

  localparam logic [8:0] SKP_WORD     = 9'h199;
  localparam int         IDX_MSB      = 12;
  localparam int         IDX_LSB      = 9;
  localparam logic [3:0] NO_OS_IDX    = 4'd15;
  localparam logic [3:0] MAX_SKP_CHG  = 4'd8;
  localparam logic [3:0] HALF_SKP_CHG = 4'd4;

  typedef enum logic [0:0] {
    PASS   = 1'b0,
    INSERT = 1'b1
  } rd_state_t;

endpackage

// File: rtl/read_processor.sv
// ---------------------------------------------------------------------------
// read_processor
// Read-side controller of the RX elastic buffer. Pops words from the
// show-ahead read port and forwards them, registered, downstream. When the
// level monitor asks for SKP insertion, whole groups of 4 SKP copies are
// emitted at the start of a SKP ordered set (index 0) or at its midpoint
// (index 4), without popping, up to 8 per ordered set.
//
// Ports:
//   rx_clk        in   read-side clock
//   rx_rst        in   asynchronous active-low reset
//   rd_data       in   head word of the buffer (valid when !buff_empty)
//   buff_empty    in   buffer has no readable word
//   elstc_buff_en in   block enable
//   SKP_add_rqst  in   insertion request level from the level monitor
//   read_en       out  pop the head word this cycle (combinational)
//   out_data      out  emitted word (registered)
//   out_valid     out  out_data holds a valid word (registered)
//   skp_added     out  pulse coincident with the 4th copy of a group
// ---------------------------------------------------------------------------
module read_processor
  import ebuf_pkg::*;
#(
  parameter int BUFFER_WIDTH = 13
) (
  input  logic                    rx_clk,
  input  logic                    rx_rst,
  input  logic [BUFFER_WIDTH-1:0] rd_data,
  input  logic                    buff_empty,
  input  logic                    elstc_buff_en,
  input  logic                    SKP_add_rqst,
  output logic                    read_en,
  output logic [BUFFER_WIDTH-1:0] out_data,
  output logic                    out_valid,
  output logic                    skp_added
);

  localparam logic [0:0] ST_PASS   = PASS;
  localparam logic [0:0] ST_INSERT = INSERT;

  logic [0:0]              state_q,     state_d;
  logic [1:0]              grp_cnt_q,   grp_cnt_d;
  logic [3:0]              ins_total_q, ins_total_d;
  logic [BUFFER_WIDTH-1:0] out_data_q,  out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    skp_added_q, skp_added_d;

  logic       head_usable_s;
  logic       is_skp_s;
  logic [3:0] idx_s;
  logic       start_s;
  logic       pop_s;
  logic       ins_inc_s;
  logic       ins_clr_s;

  // Head word decode and the insertion start condition.
  always_comb begin
    head_usable_s = elstc_buff_en && !buff_empty;
    is_skp_s      = (rd_data[8:0] == SKP_WORD);
    idx_s         = rd_data[IDX_MSB:IDX_LSB];
    // A group may only start on the first SKP of an ordered set with nothing
    // inserted yet, or on the fifth SKP after exactly one group.
    start_s       = is_skp_s && SKP_add_rqst &&
                    (((idx_s == 4'd0) && (ins_total_q == 4'd0)) ||
                     ((idx_s == HALF_SKP_CHG) && (ins_total_q == HALF_SKP_CHG)));
  end

  // FSM next state, counters and output register next values.
  always_comb begin
    state_d     = state_q;
    grp_cnt_d   = grp_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    skp_added_d = 1'b0;
    pop_s       = 1'b0;
    ins_inc_s   = 1'b0;
    // A full ordered-set allowance is released one clock after being reached.
    ins_clr_s   = (ins_total_q == MAX_SKP_CHG);

    case (state_q)
      ST_PASS: begin
        if (head_usable_s) begin
          out_data_d  = rd_data;
          out_valid_d = 1'b1;
          if (start_s) begin
            // First copy of the group; the head stays in the buffer.
            state_d   = ST_INSERT;
            grp_cnt_d = 2'd1;
            ins_inc_s = 1'b1;
          end else begin
            pop_s = 1'b1;
            if (idx_s == NO_OS_IDX) begin
              ins_clr_s = 1'b1;
            end else begin
              ins_clr_s = ins_clr_s;
            end
          end
        end else begin
          // Underflow bubble: nothing emitted, state unchanged.
          out_valid_d = 1'b0;
        end
      end
      ST_INSERT: begin
        if (!elstc_buff_en) begin
          // Abandon the partial group without signalling it.
          state_d   = ST_PASS;
          grp_cnt_d = 2'd0;
          ins_clr_s = 1'b1;
        end else begin
          out_data_d  = rd_data;
          out_valid_d = 1'b1;
          ins_inc_s   = 1'b1;
          if (grp_cnt_q == 2'd3) begin
            grp_cnt_d   = 2'd0;
            skp_added_d = 1'b1;
            state_d     = ST_PASS;
          end else begin
            grp_cnt_d = grp_cnt_q + 2'd1;
          end
        end
      end
      default: begin
        state_d   = ST_PASS;
        grp_cnt_d = 2'd0;
        ins_clr_s = 1'b1;
      end
    endcase

    if (ins_clr_s) begin
      ins_total_d = 4'd0;
    end else if (ins_inc_s) begin
      ins_total_d = ins_total_q + 4'd1;
    end else begin
      ins_total_d = ins_total_q;
    end
  end

  // Pop strobe; forced low while reset is asserted.
  always_comb begin
    read_en = rx_rst && pop_s;
  end

  // State, counters and registered outputs.
  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      state_q     <= ST_PASS;
      grp_cnt_q   <= 2'd0;
      ins_total_q <= 4'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      skp_added_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grp_cnt_q   <= grp_cnt_d;
      ins_total_q <= ins_total_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      skp_added_q <= skp_added_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign skp_added = skp_added_q;

endmodule

// File: tb/tb_read_processor.sv
module tb_read_processor;
  import ebuf_pkg::*;

  logic        rx_clk = 1'b0;
  logic        rx_rst;
  logic [12:0] rd_data;
  logic        buff_empty;
  logic        elstc_buff_en;
  logic        SKP_add_rqst;
  logic        read_en;
  logic [12:0] out_data;
  logic        out_valid;
  logic        skp_added;

  read_processor #(.BUFFER_WIDTH(13)) dut (
    .rx_clk       (rx_clk),
    .rx_rst       (rx_rst),
    .rd_data      (rd_data),
    .buff_empty   (buff_empty),
    .elstc_buff_en(elstc_buff_en),
    .SKP_add_rqst (SKP_add_rqst),
    .read_en      (read_en),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .skp_added    (skp_added)
  );

  always #5 rx_clk = ~rx_clk;

  // Buffer contents seen by the DUT, head at index 0.
  logic [12:0] q[$];
  bit          force_empty;
  int          rq_mode;   // 0 off, 1 on, 2 only at a SKP with idx 0, 3 left to caller

  int checks;
  int errors;

  // Reference model: copies still owed in the current group and SKPs added
  // in the current ordered set, plus the expected registered outputs.
  int          m_copies_left;
  int          m_ins;
  logic [12:0] m_data;
  logic        m_valid;
  logic        m_skp;

  int cnt_skp_out;
  int cnt_pulses;
  int cnt_valid;

  function automatic logic [12:0] rand_word();
    logic [7:0] sym;
    sym = 8'($urandom);
    return {4'd15, 1'b0, sym};
  endfunction

  function automatic logic [12:0] skp_word(input int idx);
    logic [3:0] i4;
    i4 = 4'(idx);
    return {i4, SKP_WORD};
  endfunction

  task automatic push_skp_os(input int len);
    for (int i = 0; i < len; i++) q.push_back(skp_word(i));
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) q.push_back(rand_word());
  endtask

  task automatic drive_inputs();
    rd_data    = (q.size() > 0) ? q[0] : 13'h0;
    buff_empty = force_empty || (q.size() == 0);
    case (rq_mode)
      0: SKP_add_rqst = 1'b0;
      1: SKP_add_rqst = 1'b1;
      2: SKP_add_rqst = (q.size() > 0) && (q[0][8:0] == SKP_WORD) && (q[0][12:9] == 4'd0);
      default: SKP_add_rqst = SKP_add_rqst;
    endcase
  endtask

  // One clock: predict from the rules, check read_en mid-cycle and the
  // registered outputs just after the edge, then update the buffer.
  task automatic step();
    logic       usable, head_skp, pop, inc, clr;
    logic [3:0] idx;
    drive_inputs();
    @(negedge rx_clk);
    idx      = rd_data[12:9];
    head_skp = (rd_data[8:0] == SKP_WORD);
    usable   = elstc_buff_en && !buff_empty;
    pop = 1'b0; inc = 1'b0; clr = (m_ins == 8);
    if (m_copies_left > 0) begin
      if (!elstc_buff_en) begin
        m_valid = 1'b0; m_skp = 1'b0; m_copies_left = 0; clr = 1'b1;
      end else begin
        m_data = rd_data; m_valid = 1'b1; inc = 1'b1;
        m_copies_left = m_copies_left - 1;
        m_skp = (m_copies_left == 0);
      end
    end else if (!usable) begin
      m_valid = 1'b0; m_skp = 1'b0;
    end else if (head_skp && SKP_add_rqst &&
                 ((idx == 4'd0 && m_ins == 0) || (idx == 4'd4 && m_ins == 4))) begin
      m_data = rd_data; m_valid = 1'b1; m_skp = 1'b0; inc = 1'b1; m_copies_left = 3;
    end else begin
      pop = 1'b1; m_data = rd_data; m_valid = 1'b1; m_skp = 1'b0;
      if (idx == 4'd15) clr = 1'b1;
    end
    m_ins = clr ? 0 : (inc ? m_ins + 1 : m_ins);

    checks++;
    assert (read_en === pop) else begin
      errors++; $error("FAIL read_en: got %b expected %b", read_en, pop);
    end
    @(posedge rx_clk);
    #1;
    checks++;
    assert (out_valid === m_valid) else begin
      errors++; $error("FAIL out_valid: got %b expected %b", out_valid, m_valid);
    end
    checks++;
    assert (out_data === m_data) else begin
      errors++; $error("FAIL out_data: got %h expected %h", out_data, m_data);
    end
    checks++;
    assert (skp_added === m_skp) else begin
      errors++; $error("FAIL skp_added: got %b expected %b", skp_added, m_skp);
    end
    if (out_valid && out_data[8:0] == SKP_WORD) cnt_skp_out++;
    if (skp_added) cnt_pulses++;
    if (out_valid) cnt_valid++;
    if (pop && q.size() > 0) void'(q.pop_front());
  endtask

  task automatic run_until_empty(input int max_cycles);
    int n;
    n = 0;
    while (q.size() > 0 && n < max_cycles) begin
      step();
      n++;
    end
    step();
    step();
    checks++;
    assert (q.size() == 0) else begin
      errors++; $error("FAIL drain_timeout: %0d words left expected 0", q.size());
    end
  endtask

  // Asynchronous reset between edges; outputs must clear immediately.
  task automatic async_reset();
    #2 rx_rst = 1'b0;
    #1;
    checks++;
    assert ({read_en, out_valid, skp_added, out_data} === 16'h0) else begin
      errors++; $error("FAIL reset_outputs: got re=%b v=%b s=%b d=%h expected all 0",
                       read_en, out_valid, skp_added, out_data);
    end
    m_copies_left = 0; m_ins = 0; m_data = 13'h0; m_valid = 1'b0; m_skp = 1'b0;
    @(posedge rx_clk);
    #1 rx_rst = 1'b1;
  endtask

  task automatic wait_copies(input int target);
    int n;
    n = 0;
    while (m_copies_left != target && n < 20) begin
      step();
      n++;
    end
    checks++;
    assert (m_copies_left == target) else begin
      errors++; $error("FAIL group_start_timeout: copies_left %0d expected %0d", m_copies_left, target);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    force_empty = 1'b0; rq_mode = 0;
    rx_rst = 1'b1; elstc_buff_en = 1'b0; SKP_add_rqst = 1'b0;
    rd_data = 13'h0; buff_empty = 1'b1;
    async_reset();

    // Plain streaming.
    elstc_buff_en = 1'b1;
    cnt_valid = 0;
    push_words(10);
    run_until_empty(30);
    checks++;
    assert (cnt_valid == 10) else begin
      errors++; $error("FAIL stream_count: got %0d expected 10", cnt_valid);
    end

    // One group at idx 0 of a 4-SKP ordered set.
    cnt_skp_out = 0; cnt_pulses = 0; rq_mode = 2;
    push_words(2); push_skp_os(4); push_words(2);
    run_until_empty(40);
    checks++;
    assert (cnt_skp_out == 8 && cnt_pulses == 1) else begin
      errors++; $error("FAIL os4_insert: got skp=%0d pulses=%0d expected 8/1", cnt_skp_out, cnt_pulses);
    end
    // Allowance cleared by the idx 15 word: a new OS takes a group again.
    cnt_pulses = 0;
    push_skp_os(4); push_words(1);
    run_until_empty(40);
    checks++;
    assert (cnt_pulses == 1) else begin
      errors++; $error("FAIL ins_total_clear: got pulses=%0d expected 1", cnt_pulses);
    end

    // Request held high through an 8-SKP ordered set.
    cnt_skp_out = 0; cnt_pulses = 0; rq_mode = 1;
    push_words(1); push_skp_os(8); push_words(2);
    run_until_empty(60);
    checks++;
    assert (cnt_skp_out == 16 && cnt_pulses == 2) else begin
      errors++; $error("FAIL os8_insert: got skp=%0d pulses=%0d expected 16/2", cnt_skp_out, cnt_pulses);
    end
    rq_mode = 0;

    // Underflow bubbles mid-stream.
    cnt_valid = 0;
    push_words(10);
    for (int i = 0; i < 3; i++) step();
    force_empty = 1'b1;
    for (int i = 0; i < 3; i++) step();
    force_empty = 1'b0;
    run_until_empty(30);
    checks++;
    assert (cnt_valid == 10) else begin
      errors++; $error("FAIL bubble_count: got %0d expected 10", cnt_valid);
    end

    // Reset on the 2nd copy of a group.
    rq_mode = 2;
    push_words(2); push_skp_os(4); push_words(2);
    wait_copies(2);
    rq_mode = 0;
    async_reset();
    cnt_pulses = 0; cnt_skp_out = 0;
    run_until_empty(40);
    checks++;
    assert (cnt_pulses == 0 && cnt_skp_out == 4) else begin
      errors++; $error("FAIL reset_mid_group: got pulses=%0d skp=%0d expected 0/4", cnt_pulses, cnt_skp_out);
    end

    // Enable dropped during a group.
    rq_mode = 2;
    push_words(1); push_skp_os(4); push_words(2);
    wait_copies(2);
    cnt_pulses = 0; cnt_skp_out = 0;
    elstc_buff_en = 1'b0;
    step();
    elstc_buff_en = 1'b1;
    rq_mode = 0;
    run_until_empty(40);
    checks++;
    assert (cnt_pulses == 0 && cnt_skp_out == 4) else begin
      errors++; $error("FAIL enable_abort: got pulses=%0d skp=%0d expected 0/4", cnt_pulses, cnt_skp_out);
    end

    // Randomized traffic against the model.
    rq_mode = 3;
    for (int i = 0; i < 400; i++) begin
      if (q.size() < 6) begin
        case ($urandom_range(0, 3))
          0: push_skp_os(4);
          1: push_skp_os(8);
          default: push_words(int'($urandom_range(1, 4)));
        endcase
      end
      elstc_buff_en = ($urandom_range(0, 15) != 0);
      force_empty   = ($urandom_range(0, 7) == 0);
      SKP_add_rqst  = $urandom_range(0, 1) != 0;
      step();
    end
    elstc_buff_en = 1'b1; force_empty = 1'b0; rq_mode = 0;
    run_until_empty(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
